alu_mul_seq: RTL and testbench

Sequencer that computes an unsigned N×N→2N-bit product by reusing the team's combinational `alu` (adder path only) with a shift-and-add algorithm, one multiplier bit per clock. It sits between a requester (board top or test harness) and a single `alu #(N)` instance. It drives the ALU operands and control and consumes its result and carry-out. The block contains no adder of its own; all addition goes through the shared ALU.

---
 rtl/alu_mul_seq.sv | 119 +++++++++++
 tb/tb_alu_mul_seq.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_seq.sv
// Shift-and-add unsigned multiplier sequencer. Retires one multiplier bit per clock
// and routes every addition through an external shared N-bit ALU.
module alu_mul_seq #(
    parameter int          N        = 4,
    parameter logic [1:0]  ADD_CTRL = 2'b10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    output logic             busy,
    output logic             done,
    output logic [2*N-1:0]   product,
    output logic [N-1:0]     alu_a,
    output logic [N-1:0]     alu_b,
    output logic [1:0]       alu_ctrl,
    input  logic [N-1:0]     alu_result,
    input  logic             alu_cout
);

    localparam int            CW       = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t            state_r,    state_next_s;
    logic [N-1:0]      m_r,        m_next_s;
    logic [N-1:0]      p_r,        p_next_s;
    logic [N-1:0]      q_r,        q_next_s;
    logic [CW-1:0]     cnt_r,      cnt_next_s;
    logic [2*N-1:0]    product_r,  product_next_s;
    logic              busy_r;
    logic              done_r;
    logic [N:0]        sum_s;
    logic [2*N-1:0]    shifted_s;

    // Partial-sum select: add the multiplicand only when the current multiplier bit is set.
    always_comb begin
        if (q_r[0]) begin
            sum_s = {alu_cout, alu_result};
        end else begin
            sum_s = {1'b0, p_r};
        end
        shifted_s = {sum_s, q_r[N-1:1]};
    end

    // Next-state and datapath update; start is only honoured in IDLE and DONE.
    always_comb begin
        state_next_s   = state_r;
        m_next_s       = m_r;
        p_next_s       = p_r;
        q_next_s       = q_r;
        cnt_next_s     = cnt_r;
        product_next_s = product_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    m_next_s     = a;
                    q_next_s     = b;
                    p_next_s     = {N{1'b0}};
                    cnt_next_s   = {CW{1'b0}};
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                {p_next_s, q_next_s} = shifted_s;
                cnt_next_s           = cnt_r + CNT_ONE;
                if (cnt_r == CNT_LAST) begin
                    product_next_s = shifted_s;
                    state_next_s   = ST_DONE;
                end else begin
                    state_next_s   = ST_RUN;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            m_r       <= {N{1'b0}};
            p_r       <= {N{1'b0}};
            q_r       <= {N{1'b0}};
            cnt_r     <= {CW{1'b0}};
            product_r <= {(2*N){1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            m_r       <= m_next_s;
            p_r       <= p_next_s;
            q_r       <= q_next_s;
            cnt_r     <= cnt_next_s;
            product_r <= product_next_s;
            busy_r    <= (state_next_s == ST_RUN);
            done_r    <= (state_next_s == ST_DONE);
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign product  = product_r;
    assign alu_a    = p_r;
    assign alu_b    = m_r;
    assign alu_ctrl = ADD_CTRL;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq: models the shared adder ALU and checks
// products against plain integer multiplication.
module tb_alu_mul_seq;

    localparam int N = 4;

    logic           clk;
    logic           reset;
    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;
    logic [N-1:0]   alu_a;
    logic [N-1:0]   alu_b;
    logic [1:0]     alu_ctrl;
    logic [N-1:0]   alu_result;
    logic           alu_cout;

    int total = 0;
    int bad   = 0;

    alu_mul_seq #(.N(N), .ADD_CTRL(2'b10)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .product    (product),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .alu_cout   (alu_cout)
    );

    // Shared ALU stand-in: only the add operation produces a sum.
    always_comb begin
        if (alu_ctrl == 2'b10) begin
            {alu_cout, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
        end else begin
            {alu_cout, alu_result} = '0;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] x, input logic [N-1:0] y);
        int unsigned r;
        r = int'(x) * int'(y);
        return r[2*N-1:0];
    endfunction

    // Issues one start pulse and follows the operation to its done cycle.
    task automatic run_mul(input logic [N-1:0] ta, input logic [N-1:0] tb_v,
                           output logic [2*N-1:0] prod, output int nbusy,
                           output bit saw_cout, output bit got_done);
        a = ta; b = tb_v; start = 1'b1;
        step();
        start = 1'b0;
        nbusy = 0; saw_cout = 1'b0; got_done = 1'b0; prod = '0;
        for (int i = 0; i < 4 * N; i++) begin
            if (done) begin
                got_done = 1'b1;
                prod = product;
                break;
            end
            if (busy) begin
                nbusy++;
                if (alu_cout) saw_cout = 1'b1;
            end
            step();
        end
    endtask

    task automatic test_reset();
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 8'h00 || alu_ctrl !== 2'b10 ||
            alu_a !== 4'h0 || alu_b !== 4'h0) begin
            bad++;
            $display("FAIL reset_values: busy=%b done=%b product=%h ctrl=%b alu_a=%h alu_b=%h required 0 0 00 10 0 0",
                     busy, done, product, alu_ctrl, alu_a, alu_b);
        end
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic [2*N-1:0] p; int nb; bit sc; bit gd;
        run_mul(4'd3, 4'd5, p, nb, sc, gd);
        total++;
        if (gd !== 1'b1 || p !== 8'h0F) begin
            bad++;
            $display("FAIL basic_product: got_done=%b product=%h required 1 0f", gd, p);
        end
        total++;
        if (nb != N) begin
            bad++;
            $display("FAIL basic_busy_cycles: got %0d required %0d", nb, N);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            total++;
            if (product !== 8'h0F || done !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL basic_hold[%0d]: product=%h done=%b busy=%b required 0f 0 0", i, product, done, busy);
            end
        end
    endtask

    task automatic test_carry();
        logic [2*N-1:0] p; int nb; bit sc; bit gd;
        run_mul(4'd15, 4'd15, p, nb, sc, gd);
        total++;
        if (gd !== 1'b1 || p !== 8'hE1) begin
            bad++;
            $display("FAIL carry_15x15: got_done=%b product=%h required 1 e1", gd, p);
        end
        total++;
        if (sc !== 1'b1) begin
            bad++;
            $display("FAIL carry_cout_seen: got %b required 1", sc);
        end
        step();
        run_mul(4'd15, 4'd0, p, nb, sc, gd);
        total++;
        if (gd !== 1'b1 || p !== 8'h00) begin
            bad++;
            $display("FAIL carry_15x0: got_done=%b product=%h required 1 00", gd, p);
        end
        step();
        run_mul(4'd0, 4'd15, p, nb, sc, gd);
        total++;
        if (gd !== 1'b1 || p !== 8'h00) begin
            bad++;
            $display("FAIL carry_0x15: got_done=%b product=%h required 1 00", gd, p);
        end
        step();
    endtask

    task automatic test_busy_lockout();
        int ndone; logic [2*N-1:0] p;
        ndone = 0; p = '0;
        a = 4'd7; b = 4'd9; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            if (i == 2) begin
                start = 1'b1; a = 4'd2; b = 4'd2;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                ndone++;
                p = product;
            end
            step();
        end
        total++;
        if (ndone != 1 || p !== 8'h3F) begin
            bad++;
            $display("FAIL busy_lockout: done_pulses=%0d product=%h required 1 3f", ndone, p);
        end
        total++;
        if (busy !== 1'b0 || product !== 8'h3F) begin
            bad++;
            $display("FAIL lockout_idle: busy=%b product=%h required 0 3f", busy, product);
        end
    endtask

    task automatic test_back_to_back();
        bit got; int gap;
        got = 1'b0;
        a = 4'd6; b = 4'd11; start = 1'b1;
        step();
        for (int i = 0; i < 4 * N && !got; i++) begin
            if (done) got = 1'b1;
            else step();
        end
        total++;
        if (!got || product !== 8'h42) begin
            bad++;
            $display("FAIL b2b_first: got_done=%b product=%h required 1 42", got, product);
        end
        a = 4'd9; b = 4'd13;
        got = 1'b0; gap = 0;
        for (int i = 0; i < 4 * N && !got; i++) begin
            step();
            gap++;
            if (done) got = 1'b1;
        end
        start = 1'b0;
        total++;
        if (!got || gap != N + 1) begin
            bad++;
            $display("FAIL b2b_spacing: got_done=%b gap=%0d required 1 %0d", got, gap, N + 1);
        end
        total++;
        if (product !== 8'h75) begin
            bad++;
            $display("FAIL b2b_second: product=%h required 75", product);
        end
        step();
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_return_idle: done=%b busy=%b required 0 0", done, busy);
        end
    endtask

    task automatic test_reset_mid_op();
        int ndone; logic [2*N-1:0] p; int nb; bit sc; bit gd;
        ndone = 0;
        a = 4'd12; b = 4'd12; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        #($urandom_range(1, 3));
        reset = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 8'h00 || alu_ctrl !== 2'b10 ||
            alu_a !== 4'h0 || alu_b !== 4'h0) begin
            bad++;
            $display("FAIL reset_async: busy=%b done=%b product=%h ctrl=%b alu_a=%h alu_b=%h required 0 0 00 10 0 0",
                     busy, done, product, alu_ctrl, alu_a, alu_b);
        end
        start = 1'b1;
        step();
        reset = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (done || busy) ndone++;
            step();
        end
        total++;
        if (ndone != 0 || product !== 8'h00) begin
            bad++;
            $display("FAIL reset_no_done: activity_cycles=%0d product=%h required 0 00", ndone, product);
        end
        run_mul(4'd12, 4'd12, p, nb, sc, gd);
        total++;
        if (gd !== 1'b1 || p !== 8'h90) begin
            bad++;
            $display("FAIL reset_recover: got_done=%b product=%h required 1 90", gd, p);
        end
        step();
    endtask

    task automatic test_random();
        logic [N-1:0] ra; logic [N-1:0] rb; logic [2*N-1:0] p; logic [2*N-1:0] exp_p;
        int nb; bit sc; bit gd; int gap;
        for (int k = 0; k < 30; k++) begin
            ra = N'($urandom);
            rb = N'($urandom);
            exp_p = ref_mul(ra, rb);
            run_mul(ra, rb, p, nb, sc, gd);
            total++;
            if (gd !== 1'b1 || p !== exp_p || nb != N) begin
                bad++;
                $display("FAIL random[%0d] %0d*%0d: got_done=%b product=%h busy_cycles=%0d required 1 %h %0d",
                         k, ra, rb, gd, p, nb, exp_p, N);
            end
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) step();
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        #2;
        test_reset();
        test_basic();
        test_carry();
        test_busy_lockout();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
